exc_flush_ctrl: RTL
===================

Name: exc_flush_ctrl

Overview:
Exception sequencing controller for the ID/EX control path.
- Collects up to six simultaneous exception requests and selects one with a fixed priority.
- Captures the cause and trap value, then runs the pipeline-flush handshake to completion.
- Issues a one-cycle CSR-save / PC-set pulse at the end of the handshake.
- Sits between the decoder/LSU error sources and the CSR/IF blocks. It guarantees a one-hot exception priority vector whenever it is flushing.

Parameters:
XLEN, 32, width of trap value inputs/outputs
FlushTimeout, 16, max cycles spent in FLUSH waiting for flush_ack_i before forcing the trap (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
exc_req_i  in  6  request vector; bit0 fetch_err, bit1 illegal, bit2 ecall, bit3 ebrk, bit4 load_err, bit5 store_err
instr_tval_i  in  XLEN  faulting instruction bits / fetch address
lsu_addr_i  in  XLEN  faulting LSU address
flush_ack_i  in  1  pipeline reports flush complete
flush_req_o  out  1  request pipeline flush
halt_if_o  out  1  stall fetch/decode while not IDLE
exc_prio_o  out  6  latched one-hot selected exception (same bit order as exc_req_i)
exc_cause_o  out  5  latched mcause code
exc_tval_o  out  XLEN  latched mtval
csr_save_o  out  1  one-cycle pulse: write mepc/mcause/mtval
pc_set_o  out  1  one-cycle pulse: redirect fetch to trap vector
flush_timeout_o  out  1  sticky flag: a flush timed out

Behaviour:
- Reset (synchronous, active-high, may arrive in any state): all outputs 0, state IDLE, counter 0, sticky flag cleared.
- FSM states: IDLE, FLUSH, TRAP.
- IDLE, |exc_req_i=1:
  - Register the encoder result into exc_prio_o, exc_cause_o and exc_tval_o.
  - Next state FLUSH; counter cleared.
- IDLE, exc_req_i=0: stay IDLE; flush_ack_i is ignored.
- Priority, highest first: store_err > load_err > fetch_err > illegal > ecall > ebrk. Unselected requests are dropped, not queued.
- Cause codes: fetch_err 1, illegal 2, ebrk 3, load_err 5, store_err 7, ecall 11.
- tval source:
  - fetch_err, illegal: instr_tval_i.
  - load_err, store_err: lsu_addr_i.
  - ecall, ebrk: 0.
- FLUSH:
  - flush_req_o=1. Counter increments each cycle.
  - flush_ack_i=1 moves to TRAP.
  - Otherwise, when the counter reaches FlushTimeout-1, move to TRAP and set flush_timeout_o=1.
  - If ack and timeout land in the same cycle, ack wins and flush_timeout_o is not set.
- TRAP: csr_save_o=1 and pc_set_o=1 for exactly one cycle; flush_req_o=0; next state IDLE.
- halt_if_o=1 in FLUSH and TRAP.
- exc_req_i is ignored outside IDLE.
- exc_prio_o, exc_cause_o and exc_tval_o hold their values until the next capture; they are not cleared in IDLE.
- Latency:
  - Request in cycle N gives flush_req_o in cycle N+1.
  - Ack in cycle M gives csr_save_o/pc_set_o in cycle M+1 and IDLE in cycle M+2.
  - A new request can be accepted in cycle M+2.
- Minimum trap sequence is 3 cycles (ack in the first FLUSH cycle).
- Counter width: $clog2(FlushTimeout+1); it saturates and never wraps.
- Embedded assertion (default clock/reset macros): when the state is FLUSH, exc_prio_o is one-hot.
- Embedded assertion: csr_save_o is never high on two consecutive cycles.
- Static assertion: FlushTimeout>=1.

Decomposition:
- Shared package exc_ctrl_pkg holds:
  - exc_idx_e bit-index enum;
  - cause localparams;
  - exc_state_e {IDLE, FLUSH, TRAP}.
- Sub-module exc_prio_enc is purely combinational: exc_req_i in; one-hot vector, cause and tval-select out.
- The FSM, counter and capture registers live in the top.

Test Plan:
1. exc_req_i=6'b000010 with instr_tval_i=32'hDEAD_BEEF, flush_ack_i asserted in the 2nd FLUSH cycle -> flush_req_o high 2 cycles; exc_prio_o=6'b000010, exc_cause_o=2, exc_tval_o=32'hDEAD_BEEF; csr_save_o and pc_set_o pulse for 1 cycle, then IDLE.
2. exc_req_i=6'b111111 with lsu_addr_i=32'h1000 -> exc_prio_o=6'b100000, cause 7, tval 32'h1000. Repeat with exc_req_i=6'b001100 -> exc_prio_o=6'b000100, cause 11, tval 0.
3. flush_ack_i held 0, FlushTimeout=16 -> exactly 16 FLUSH cycles, then TRAP pulse; flush_timeout_o=1 and stays set through later traps until rst_i.
4. flush_ack_i=1 on the 16th FLUSH cycle -> TRAP taken, flush_timeout_o stays 0.
5. New exc_req_i=6'b010000 raised during FLUSH and TRAP -> ignored, latched cause unchanged. Still high in the first IDLE cycle -> captured, flush_req_o one cycle later.
6. rst_i asserted for 1 cycle mid-FLUSH -> next cycle all outputs 0, state IDLE; a following request runs a normal sequence.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared types for the exception sequencing controller: request bit indices,
// mcause codes, FSM state encoding and the trap-value source selector.
package exc_ctrl_pkg;

    typedef enum int unsigned {
        EXC_FETCH   = 0,
        EXC_ILLEGAL = 1,
        EXC_ECALL   = 2,
        EXC_EBRK    = 3,
        EXC_LOAD    = 4,
        EXC_STORE   = 5
    } exc_idx_e;

    localparam int unsigned EXC_NUM = 6;

    localparam logic [4:0] CAUSE_FETCH   = 5'd1;
    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_EBRK    = 5'd3;
    localparam logic [4:0] CAUSE_LOAD    = 5'd5;
    localparam logic [4:0] CAUSE_STORE   = 5'd7;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } exc_state_e;

    typedef enum logic [1:0] {
        TVAL_ZERO  = 2'd0,
        TVAL_INSTR = 2'd1,
        TVAL_LSU   = 2'd2
    } tval_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: store > load > fetch > illegal > ecall > ebrk.
// Purely combinational, zero latency; no flow control.
// Produces the one-hot winner, its mcause code and where mtval comes from.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic [EXC_NUM-1:0] exc_req_i,
    output logic [EXC_NUM-1:0] onehot_o,
    output logic [4:0]         cause_o,
    output tval_sel_e          tval_sel_o
);

    always_comb begin
        onehot_o   = '0;
        cause_o    = '0;
        tval_sel_o = TVAL_ZERO;
        if (exc_req_i[EXC_STORE]) begin
            onehot_o[EXC_STORE] = 1'b1;
            cause_o             = CAUSE_STORE;
            tval_sel_o          = TVAL_LSU;
        end else if (exc_req_i[EXC_LOAD]) begin
            onehot_o[EXC_LOAD] = 1'b1;
            cause_o            = CAUSE_LOAD;
            tval_sel_o         = TVAL_LSU;
        end else if (exc_req_i[EXC_FETCH]) begin
            onehot_o[EXC_FETCH] = 1'b1;
            cause_o             = CAUSE_FETCH;
            tval_sel_o          = TVAL_INSTR;
        end else if (exc_req_i[EXC_ILLEGAL]) begin
            onehot_o[EXC_ILLEGAL] = 1'b1;
            cause_o               = CAUSE_ILLEGAL;
            tval_sel_o            = TVAL_INSTR;
        end else if (exc_req_i[EXC_ECALL]) begin
            onehot_o[EXC_ECALL] = 1'b1;
            cause_o             = CAUSE_ECALL;
        end else if (exc_req_i[EXC_EBRK]) begin
            onehot_o[EXC_EBRK] = 1'b1;
            cause_o            = CAUSE_EBRK;
        end
    end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception sequencer: capture winner, run flush handshake, pulse CSR save / PC set.
// Latency: request -> flush_req next cycle; ack -> trap pulse next cycle, IDLE after.
// Backpressure: waits on flush_ack_i up to FlushTimeout cycles, then forces the trap.
module exc_flush_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FlushTimeout = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [EXC_NUM-1:0] exc_req_i,
    input  logic [XLEN-1:0]    instr_tval_i,
    input  logic [XLEN-1:0]    lsu_addr_i,
    input  logic               flush_ack_i,
    output logic               flush_req_o,
    output logic               halt_if_o,
    output logic [EXC_NUM-1:0] exc_prio_o,
    output logic [4:0]         exc_cause_o,
    output logic [XLEN-1:0]    exc_tval_o,
    output logic               csr_save_o,
    output logic               pc_set_o,
    output logic               flush_timeout_o
);

    localparam int unsigned CNT_W = $clog2(FlushTimeout + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FlushTimeout - 1);

    if (FlushTimeout < 1) begin : g_bad_timeout
        $error("FlushTimeout must be at least 1");
    end

    exc_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [EXC_NUM-1:0] enc_onehot;
    logic [4:0]         enc_cause;
    tval_sel_e          enc_tval_sel;
    logic [XLEN-1:0]    enc_tval;

    exc_prio_enc u_prio_enc (
        .exc_req_i  (exc_req_i),
        .onehot_o   (enc_onehot),
        .cause_o    (enc_cause),
        .tval_sel_o (enc_tval_sel)
    );

    always_comb begin
        enc_tval = '0;
        case (enc_tval_sel)
            TVAL_INSTR: enc_tval = instr_tval_i;
            TVAL_LSU:   enc_tval = lsu_addr_i;
            default:    enc_tval = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            exc_prio_o      <= '0;
            exc_cause_o     <= '0;
            exc_tval_o      <= '0;
            flush_timeout_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|exc_req_i) begin
                        exc_prio_o  <= enc_onehot;
                        exc_cause_o <= enc_cause;
                        exc_tval_o  <= enc_tval;
                        cnt_q       <= '0;
                        state_q     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // An ack landing on the last allowed cycle is a clean flush.
                    if (flush_ack_i) begin
                        state_q <= TRAP;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q         <= TRAP;
                        flush_timeout_o <= 1'b1;
                    end
                end
                TRAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign flush_req_o = (state_q == FLUSH);
    assign halt_if_o   = (state_q != IDLE);
    assign csr_save_o  = (state_q == TRAP);
    assign pc_set_o    = (state_q == TRAP);

    a_prio_onehot_in_flush: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == FLUSH) |-> $onehot(exc_prio_o)
    );

    a_csr_save_single: assert property (
        @(posedge clk_i) disable iff (rst_i)
        csr_save_o |=> !csr_save_o
    );

endmodule
